seg_pattern_capture: RTL and testbench



---
 rtl/seg_pkg.sv | 19 +
 rtl/seg_glyph_decode.sv | 31 +++
 rtl/seg_pattern_capture.sv | 157 +++++++++++++++
 tb/tb_seg_pattern_capture.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment capture path: FSM states and the
// active-low glyph table used by both the display encoder and the decoder.
package seg_pkg;

  typedef enum logic [1:0] {QUAL, SCAN, HOLD} seg_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // index = nibble, value = active-low g..a pattern
  localparam logic [6:0] SEG_GLYPH [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
    return SEG_GLYPH[nibble];
  endfunction

endpackage

// File: rtl/seg_glyph_decode.sv
// Combinational decode of one active-low seven-segment pattern back to a nibble,
// with blank/illegal-glyph flags and the decimal point.
module seg_glyph_decode
  import seg_pkg::*;
(
  input  logic [7:0] pattern,
  output logic [3:0] nibble,
  output logic       blank,
  output logic       err,
  output logic       dp
);

  always_comb begin
    nibble = 4'h0;
    blank  = 1'b0;
    err    = 1'b1;
    dp     = ~pattern[7];
    if (pattern[6:0] == SEG_BLANK) begin
      blank = 1'b1;
      err   = 1'b0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (pattern[6:0] == SEG_GLYPH[i]) begin
          nibble = 4'(i);
          err    = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/seg_pattern_capture.sv
// Samples a bank of active-low seven-segment digits once they are stable, decodes
// one digit per cycle and presents the result on a valid/ready handshake.
// Optional SEG_CAPTURE_DEDUP_EN suppresses captures identical to the last one presented.
module seg_pattern_capture
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [8*NUM_DIGITS-1:0] seg_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_value,
  output logic [NUM_DIGITS-1:0]   out_blank,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic [NUM_DIGITS-1:0]   out_dp
);

  localparam int              IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]      CNT_MAX  = 8'(STABLE_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  seg_state_t state_reg, state_next;

  logic [8*NUM_DIGITS-1:0] prev_reg;
  logic [8*NUM_DIGITS-1:0] snap_reg;
  logic [7:0]              cnt_reg;
  logic [IDX_W-1:0]        idx_reg;

  logic [4*NUM_DIGITS-1:0] value_reg, value_next;
  logic [NUM_DIGITS-1:0]   blank_reg, blank_next;
  logic [NUM_DIGITS-1:0]   err_reg, err_next;
  logic [NUM_DIGITS-1:0]   dp_reg, dp_next;

  logic [7:0] snap_digit [NUM_DIGITS];
  logic [7:0] dec_in;
  logic [3:0] dec_nibble;
  logic       dec_blank, dec_err, dec_dp;

  logic stable, qualify, scan_last, accept, dup, clear_cnt;

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign snap_digit[gi] = snap_reg[8*gi +: 8];
  end

  always_comb begin
    dec_in = snap_digit[0];
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) dec_in = snap_digit[i];
    end
  end

  seg_glyph_decode u_decode (
    .pattern (dec_in),
    .nibble  (dec_nibble),
    .blank   (dec_blank),
    .err     (dec_err),
    .dp      (dec_dp)
  );

  // Result vectors with the digit under decode merged in; on the last SCAN
  // cycle this is the complete capture, which dedup compares against.
  always_comb begin
    value_next = value_reg;
    blank_next = blank_reg;
    err_next   = err_reg;
    dp_next    = dp_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_reg == IDX_W'(i)) begin
        value_next[4*i +: 4] = dec_nibble;
        blank_next[i]        = dec_blank;
        err_next[i]          = dec_err;
        dp_next[i]           = dec_dp;
      end
    end
  end

  assign stable    = (seg_in == prev_reg);
  assign qualify   = stable && (cnt_reg == CNT_MAX);
  assign scan_last = (state_reg == SCAN) && (idx_reg == IDX_LAST);
  assign accept    = (state_reg == HOLD) && out_ready;
  assign clear_cnt = accept || (scan_last && dup);

`ifdef SEG_CAPTURE_DEDUP_EN
  logic [7*NUM_DIGITS-1:0] last_reg;
  logic                    have_last_reg;

  assign dup = have_last_reg && ({value_next, blank_next, err_next, dp_next} == last_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      last_reg      <= '0;
      have_last_reg <= 1'b0;
    end else if (scan_last && !dup) begin
      last_reg      <= {value_next, blank_next, err_next, dp_next};
      have_last_reg <= 1'b1;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_reg <= QUAL;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      QUAL:    if (qualify) state_next = SCAN;
      SCAN:    if (scan_last) state_next = dup ? QUAL : HOLD;
      HOLD:    if (out_ready) state_next = QUAL;
      default: state_next = QUAL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_reg  <= '1;
      cnt_reg   <= '0;
      snap_reg  <= '0;
      idx_reg   <= '0;
      value_reg <= '0;
      blank_reg <= '0;
      err_reg   <= '0;
      dp_reg    <= '0;
    end else begin
      prev_reg <= seg_in;
      // Leaving HOLD (or skipping it) forces a full requalification.
      if (clear_cnt || !stable) cnt_reg <= '0;
      else if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 8'd1;

      if (state_reg == QUAL && qualify) begin
        snap_reg <= seg_in;
        idx_reg  <= '0;
      end

      if (state_reg == SCAN) begin
        value_reg <= value_next;
        blank_reg <= blank_next;
        err_reg   <= err_next;
        dp_reg    <= dp_next;
        idx_reg   <= idx_reg + 1'b1;
      end
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign out_value = value_reg;
  assign out_blank = blank_reg;
  assign out_err   = err_reg;
  assign out_dp    = dp_reg;

endmodule

// File: tb/tb_seg_pattern_capture.sv
// Directed self-checking bench for seg_pattern_capture (NUM_DIGITS=6, STABLE_CYCLES=4).
module tb_seg_pattern_capture;

  localparam logic [47:0] P1  = 48'hC0_F9_A4_B0_99_92;  // 0x012345
  localparam logic [47:0] P2  = 48'hF9_F9_F9_F9_F9_F9;  // 0x111111
  localparam logic [47:0] PBE = 48'hC0_C0_C0_24_55_FF;  // blank / err / dp mix

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] seg_in;
  logic        out_valid;
  logic        out_ready;
  logic [23:0] out_value;
  logic [5:0]  out_blank;
  logic [5:0]  out_err;
  logic [5:0]  out_dp;

  int vectors    = 0;
  int miscompares = 0;

  seg_pattern_capture #(.NUM_DIGITS(6), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg_in    (seg_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_value (out_value),
    .out_blank (out_blank),
    .out_err   (out_err),
    .out_dp    (out_dp)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int k);
    k = 0;
    while (!out_valid && k < budget) begin
      tick();
      k++;
    end
  endtask

  initial begin
    int k;
    int first_k;
    int pulses;
    logic [23:0] cap_value;
    logic [5:0]  cap_blank, cap_err, cap_dp;
    logic        vld_hist [0:25];

    rst       = 1'b1;
    seg_in    = '1;
    out_ready = 1'b0;
    tick();
    tick();
    chk("reset_valid", 64'(out_valid), 64'd0);
    chk("reset_value", 64'(out_value), 64'd0);
    chk("reset_blank", 64'(out_blank), 64'd0);
    chk("reset_err",   64'(out_err),   64'd0);
    chk("reset_dp",    64'(out_dp),    64'd0);
    rst = 1'b0;

    // Legal value, ready high: one pulse within 20 cycles, 4+1+6 after settling
    seg_in    = P1;
    out_ready = 1'b1;
    first_k   = 0;
    pulses    = 0;
    cap_value = '0; cap_blank = '0; cap_err = '0; cap_dp = '0;
    for (int i = 0; i < 26; i++) vld_hist[i] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      vld_hist[i] = out_valid;
      if (out_valid) begin
        pulses++;
        if (first_k == 0) begin
          first_k   = i;
          cap_value = out_value;
          cap_blank = out_blank;
          cap_err   = out_err;
          cap_dp    = out_dp;
        end
      end
    end
    $display("legal: first valid at cycle %0d, value %06h, pulses %0d", first_k, cap_value, pulses);
    chk("legal_latency", 64'(first_k), 64'd11);
    chk("legal_value",   64'(cap_value), 64'h012345);
    chk("legal_blank",   64'(cap_blank), 64'd0);
    chk("legal_err",     64'(cap_err),   64'd0);
    chk("legal_dp",      64'(cap_dp),    64'd0);
    chk("legal_drop",    64'(vld_hist[first_k + 1]), 64'd0);
    chk("legal_pulses",  64'(pulses), 64'd1);

    // Instability: toggling every 3 cycles never qualifies
    do_reset();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) seg_in = ((i / 3) % 2 == 1) ? P2 : P1;
      tick();
      if (out_valid) pulses++;
    end
    $display("unstable: valid cycles %0d", pulses);
    chk("unstable_valid", 64'(pulses), 64'd0);

    // Blank / illegal / decimal point
    do_reset();
    out_ready = 1'b0;
    seg_in    = PBE;
    wait_valid(40, k);
    $display("mix: valid after %0d, value %06h blank %b err %b dp %b", k, out_value, out_blank, out_err, out_dp);
    chk("mix_latency", 64'(k), 64'd11);
    chk("mix_value",   64'(out_value), 64'h000200);
    chk("mix_blank",   64'(out_blank), 64'b000001);
    chk("mix_err",     64'(out_err),   64'b000010);
    chk("mix_dp",      64'(out_dp),    64'b000110);

    // Backpressure: HOLD stays put while seg_in moves
    do_reset();
    out_ready = 1'b0;
    seg_in    = P1;
    wait_valid(40, k);
    chk("bp_latency", 64'(k), 64'd11);
    seg_in = P2;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 64'(out_valid), 64'd1);
      chk("bp_hold_value", 64'(out_value), 64'h012345);
    end
    out_ready = 1'b1;
    tick();
    chk("bp_drop", 64'(out_valid), 64'd0);
    wait_valid(40, k);
    $display("backpressure: requalified after %0d, value %06h", k, out_value);
    chk("bp_requal_latency", 64'(k), 64'd10);
    chk("bp_requal_value",   64'(out_value), 64'h111111);

    // Reset during the third SCAN cycle
    do_reset();
    out_ready = 1'b1;
    seg_in    = P1;
    for (int i = 0; i < 7; i++) tick();
    rst = 1'b1;
    tick();
    chk("midscan_valid", 64'(out_valid), 64'd0);
    chk("midscan_value", 64'(out_value), 64'd0);
    chk("midscan_blank", 64'(out_blank), 64'd0);
    chk("midscan_err",   64'(out_err),   64'd0);
    chk("midscan_dp",    64'(out_dp),    64'd0);
    rst = 1'b0;
    wait_valid(40, k);
    $display("midscan: fresh capture after %0d, value %06h", k, out_value);
    chk("midscan_requal", 64'(k), 64'd11);
    chk("midscan_value2", 64'(out_value), 64'h012345);

    // Constant input, ready high, 200 cycles
    do_reset();
    out_ready = 1'b1;
    seg_in    = P1;
    pulses    = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (out_valid) pulses++;
    end
    $display("repeat: %0d valid pulses in 200 cycles", pulses);
`ifdef SEG_CAPTURE_DEDUP_EN
    chk("repeat_pulses", 64'(pulses), 64'd1);
`else
    chk("repeat_pulses", 64'(pulses), 64'd18);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
